idu: RTL and testbench

- Instruction decode stage, directly downstream of the fetch stage.
- Accepts one 64-bit fetch packet {inst[63:32], pc[31:0]} per valid/ready handshake. Decodes RV32I fields, immediate and instruction class, then holds the result in a single output register stage toward the execute stage.
- Provides full backpressure and a synchronous flush for redirects.

---
 rtl/idu.sv | 163 ++++++++++++++++
 tb/tb_idu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu.sv
// idu: RV32I instruction decode stage with one registered output slot.
// Accepts {inst, pc} from fetch, decodes fields/immediate/class and holds the
// result for execute under valid/ready backpressure, with a synchronous flush.
// Optional macro IDU_ILLEGAL_CHK_EN enables the registered illegal-inst flag.
module idu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_valid,
    input  logic [63:0]           ifu_data,
    output logic                  idu_ready,
    input  logic                  flush,
    output logic                  idu_valid,
    input  logic                  exu_ready,
    output logic [WIDTH-1:0]      out_pc,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_imm,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_wen,
    output logic [3:0]            out_type,
    output logic                  out_illegal
);

    localparam logic [3:0] T_R      = 4'd0;
    localparam logic [3:0] T_I      = 4'd1;
    localparam logic [3:0] T_LOAD   = 4'd2;
    localparam logic [3:0] T_STORE  = 4'd3;
    localparam logic [3:0] T_BRANCH = 4'd4;
    localparam logic [3:0] T_JAL    = 4'd5;
    localparam logic [3:0] T_JALR   = 4'd6;
    localparam logic [3:0] T_LUI    = 4'd7;
    localparam logic [3:0] T_AUIPC  = 4'd8;
    localparam logic [3:0] T_SYSTEM = 4'd9;
    localparam logic [3:0] T_UNK    = 4'd15;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]      pc;
        logic [31:0]           inst;
        logic [31:0]           imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_wen;
        logic [3:0]            typ;
    } dec_t;

    state_t      state_q, state_d;
    dec_t        pkt_q, dec_d;
    logic        accept;
    logic        wen_class;
    logic [31:0] inst;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst = ifu_data[63:32];

    // Immediate formats, all sign-extended from inst[31].
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Handshake, accept and next-state; flush wins over accept and drain.
    always_comb begin
        state_d   = state_q;
        idu_valid = (state_q == S_FULL);
        idu_ready = (state_q == S_EMPTY) || exu_ready;
        accept    = ifu_valid && idu_ready && !flush;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = S_FULL;
        end else if (exu_ready) begin
            state_d = S_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Combinational decode of the incoming fetch packet.
    always_comb begin
        dec_d      = '0;
        wen_class  = 1'b0;
        dec_d.pc   = ifu_data[WIDTH-1:0];
        dec_d.inst = inst;
        dec_d.rs1  = inst[15 +: REG_ADDR_W];
        dec_d.rs2  = inst[20 +: REG_ADDR_W];
        dec_d.rd   = inst[7 +: REG_ADDR_W];
        dec_d.typ  = T_UNK;
        case (inst[6:0])
            7'b0110011: begin dec_d.typ = T_R;                             wen_class = 1'b1; end
            7'b0010011: begin dec_d.typ = T_I;      dec_d.imm = imm_i;     wen_class = 1'b1; end
            7'b0000011: begin dec_d.typ = T_LOAD;   dec_d.imm = imm_i;     wen_class = 1'b1; end
            7'b0100011: begin dec_d.typ = T_STORE;  dec_d.imm = imm_s;     end
            7'b1100011: begin dec_d.typ = T_BRANCH; dec_d.imm = imm_b;     end
            7'b1101111: begin dec_d.typ = T_JAL;    dec_d.imm = imm_j;     wen_class = 1'b1; end
            7'b1100111: begin dec_d.typ = T_JALR;   dec_d.imm = imm_i;     wen_class = 1'b1; end
            7'b0110111: begin dec_d.typ = T_LUI;    dec_d.imm = imm_u;     wen_class = 1'b1; end
            7'b0010111: begin dec_d.typ = T_AUIPC;  dec_d.imm = imm_u;     wen_class = 1'b1; end
            7'b1110011: begin dec_d.typ = T_SYSTEM; dec_d.imm = imm_i;     end
            default:    begin dec_d.typ = T_UNK;    end
        endcase
        dec_d.rd_wen = wen_class && (dec_d.rd != '0);
    end

    // Output packet register; loads only on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= '0;
        end else if (accept) begin
            pkt_q <= dec_d;
        end
    end

    assign out_pc     = pkt_q.pc;
    assign out_inst   = pkt_q.inst;
    assign out_imm    = pkt_q.imm;
    assign out_rs1    = pkt_q.rs1;
    assign out_rs2    = pkt_q.rs2;
    assign out_rd     = pkt_q.rd;
    assign out_rd_wen = pkt_q.rd_wen;
    assign out_type   = pkt_q.typ;

`ifdef IDU_ILLEGAL_CHK_EN
    logic illegal_q, illegal_d;
    logic bad_funct7, bad_e_idx;

    // Illegal-instruction detection on the incoming packet.
    always_comb begin
        bad_funct7 = (dec_d.typ == T_R) && (inst[31:25] != 7'b0000000)
                     && (inst[31:25] != 7'b0100000);
        bad_e_idx  = (REG_ADDR_W < 5) && (inst[19] || inst[24] || inst[11]);
        illegal_d  = (dec_d.typ == T_UNK) || (inst[1:0] != 2'b11) || bad_funct7 || bad_e_idx;
    end

    // Illegal flag travels with the packet register.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= illegal_d;
        end
    end

    assign out_illegal = illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_idu.sv
// tb_idu: scoreboard bench for the idu decode stage.
module tb_idu;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic [63:0] ifu_data;
    logic        idu_ready;
    logic        flush;
    logic        idu_valid;
    logic        exu_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [3:0]  out_type;
    logic        out_illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  typ;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    idu dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_valid  (ifu_valid),
        .ifu_data   (ifu_data),
        .idu_ready  (idu_ready),
        .flush      (flush),
        .idu_valid  (idu_valid),
        .exu_ready  (exu_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_imm    (out_imm),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_rd_wen (out_rd_wen),
        .out_type   (out_type),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder.
    function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
        exp_t r;
        r.pc  = pc;
        r.inst = inst;
        r.rs1 = inst[19:15];
        r.rs2 = inst[24:20];
        r.rd  = inst[11:7];
        r.imm = 32'd0;
        r.wen = 1'b0;
        r.typ = 4'd15;
        case (inst[6:0])
            7'h33: begin r.typ = 4'd0; r.wen = 1'b1; end
            7'h13: begin r.typ = 4'd1; r.wen = 1'b1; r.imm = 32'($signed(inst[31:20])); end
            7'h03: begin r.typ = 4'd2; r.wen = 1'b1; r.imm = 32'($signed(inst[31:20])); end
            7'h23: begin r.typ = 4'd3; r.imm = 32'($signed({inst[31:25], inst[11:7]})); end
            7'h63: begin r.typ = 4'd4;
                         r.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})); end
            7'h6F: begin r.typ = 4'd5; r.wen = 1'b1;
                         r.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})); end
            7'h67: begin r.typ = 4'd6; r.wen = 1'b1; r.imm = 32'($signed(inst[31:20])); end
            7'h37: begin r.typ = 4'd7; r.wen = 1'b1; r.imm = inst & 32'hFFFF_F000; end
            7'h17: begin r.typ = 4'd8; r.wen = 1'b1; r.imm = inst & 32'hFFFF_F000; end
            7'h73: begin r.typ = 4'd9; r.imm = 32'($signed(inst[31:20])); end
            default: ;
        endcase
        if (r.rd == 5'd0) r.wen = 1'b0;
`ifdef IDU_ILLEGAL_CHK_EN
        r.ill = (r.typ == 4'd15) || (inst[1:0] != 2'b11) ||
                ((r.typ == 4'd0) && (inst[31:25] != 7'h00) && (inst[31:25] != 7'h20));
`else
        r.ill = 1'b0;
`endif
        return r;
    endfunction

    // Scoreboard update on each active edge from the bench's own handshake model.
    always @(posedge clk) begin
        logic exp_ready;
        if (rst || flush) begin
            sb.delete();
        end else begin
            exp_ready = (sb.size() == 0) || exu_ready;
            if (sb.size() != 0 && exu_ready) void'(sb.pop_front());
            if (ifu_valid && exp_ready) sb.push_back(ref_dec(ifu_data[63:32], ifu_data[31:0]));
        end
    end

    // Output comparison away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 32'(idu_valid), 32'(sb.size() != 0));
            check("ready", 32'(idu_ready), 32'((sb.size() == 0) || exu_ready));
            if (sb.size() != 0) begin
                e = sb[0];
                check("pc",   out_pc, e.pc);
                check("inst", out_inst, e.inst);
                check("imm",  out_imm, e.imm);
                check("rs1",  32'(out_rs1), 32'(e.rs1));
                check("rs2",  32'(out_rs2), 32'(e.rs2));
                check("rd",   32'(out_rd), 32'(e.rd));
                check("wen",  32'(out_rd_wen), 32'(e.wen));
                check("type", 32'(out_type), 32'(e.typ));
                check("ill",  32'(out_illegal), 32'(e.ill));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic er, input logic fl);
        ifu_valid = v;
        ifu_data  = {inst, pc};
        exu_ready = er;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A_INST = 32'h00A00113;
    localparam logic [31:0] B_INST = 32'h40208033;
    localparam logic [31:0] C_INST = 32'h0000A183;
    localparam logic [31:0] D_INST = 32'h004000EF;

    logic [6:0] ops[11];
    logic [31:0] rnd;

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h00};
        rst = 1'b1; ifu_valid = 1'b0; ifu_data = '0; exu_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(idu_valid), 32'd0);
        check("rst_pc",    out_pc, 32'd0);
        check("rst_inst",  out_inst, 32'd0);
        check("rst_imm",   out_imm, 32'd0);
        check("rst_type",  32'(out_type), 32'd0);
        check("rst_wen",   32'(out_rd_wen), 32'd0);
        check("rst_ill",   32'(out_illegal), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(idu_ready), 32'd1);

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h80000000, 1'b1, 1'b0);
        check("addi_valid", 32'(idu_valid), 32'd1);
        check("addi_pc",    out_pc, 32'h80000000);
        check("addi_imm",   out_imm, 32'd5);
        check("addi_rd",    32'(out_rd), 32'd1);
        check("addi_rs1",   32'(out_rs1), 32'd0);
        check("addi_type",  32'(out_type), 32'd1);
        check("addi_wen",   32'(out_rd_wen), 32'd1);
        check("addi_ill",   32'(out_illegal), 32'd0);
        // lui x2
        drive(1'b1, 32'h12345137, 32'h80000004, 1'b1, 1'b0);
        check("lui_imm",  out_imm, 32'h12345000);
        check("lui_type", 32'(out_type), 32'd7);
        check("lui_rd",   32'(out_rd), 32'd2);
        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h80000008, 1'b1, 1'b0);
        check("beq_imm",  out_imm, 32'hFFFFFFFC);
        check("beq_type", 32'(out_type), 32'd4);
        check("beq_wen",  32'(out_rd_wen), 32'd0);
        // sw x5,-8(x2)
        drive(1'b1, 32'hFE512C23, 32'h8000000C, 1'b1, 1'b0);
        check("sw_imm",  out_imm, 32'hFFFFFFF8);
        check("sw_rs1",  32'(out_rs1), 32'd2);
        check("sw_rs2",  32'(out_rs2), 32'd5);
        check("sw_type", 32'(out_type), 32'd3);
        check("sw_wen",  32'(out_rd_wen), 32'd0);
        // all-zero word
        drive(1'b1, 32'h00000000, 32'h80000010, 1'b1, 1'b0);
        check("zero_type", 32'(out_type), 32'd15);
        check("zero_imm",  out_imm, 32'd0);
`ifdef IDU_ILLEGAL_CHK_EN
        check("zero_ill", 32'(out_illegal), 32'd1);
`else
        check("zero_ill", 32'(out_illegal), 32'd0);
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("idle_valid", 32'(idu_valid), 32'd0);

        // Backpressure: A held for 3 cycles while B waits.
        drive(1'b1, A_INST, 32'h100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, B_INST, 32'h104, 1'b0, 1'b0);
            check("stall_inst",  out_inst, A_INST);
            check("stall_pc",    out_pc, 32'h100);
            check("stall_ready", 32'(idu_ready), 32'd0);
        end
        drive(1'b1, B_INST, 32'h104, 1'b1, 1'b0);
        check("b2b_valid", 32'(idu_valid), 32'd1);
        check("b2b_inst",  out_inst, B_INST);
        check("b2b_type",  32'(out_type), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("nodup_valid", 32'(idu_valid), 32'd0);

        // Flush while full with an incoming packet.
        drive(1'b1, C_INST, 32'h200, 1'b0, 1'b0);
        drive(1'b1, D_INST, 32'h204, 1'b1, 1'b1);
        check("flush_valid", 32'(idu_valid), 32'd0);
        check("flush_keep",  out_inst, C_INST);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_drop", 32'(idu_valid), 32'd0);
        drive(1'b1, D_INST, 32'h208, 1'b1, 1'b1);
        check("flush_empty", 32'(idu_valid), 32'd0);

        // Reset in the middle of a stall.
        drive(1'b1, A_INST, 32'h300, 1'b0, 1'b0);
        drive(1'b1, B_INST, 32'h304, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, B_INST, 32'h304, 1'b0, 1'b0);
        check("mrst_valid", 32'(idu_valid), 32'd0);
        check("mrst_pc",    out_pc, 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("mrst_after", 32'(idu_valid), 32'd0);

        // Random traffic, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            drive(($urandom_range(3, 0) != 0),
                  {rnd[31:7], ops[$urandom_range(10, 0)]},
                  32'($urandom) & 32'hFFFF_FFFC,
                  ($urandom_range(2, 0) != 0),
                  ($urandom_range(7, 0) == 0));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
